// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 timing constants, pipeline control bundle and the
// framebuffer cell-address helper for the VGA display path.
package vga_timing_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FRONT   = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BACK    = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam logic [9:0] HS_START  = H_VISIBLE + H_FRONT;
  localparam logic [9:0] HS_END    = HS_START + H_SYNC;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FRONT   = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BACK    = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam logic [9:0] VS_START  = V_VISIBLE + V_FRONT;
  localparam logic [9:0] VS_END    = VS_START + V_SYNC;

  localparam int unsigned CELL_SHIFT   = 3;
  localparam logic [12:0] COLS         = 13'(H_VISIBLE >> CELL_SHIFT);
  localparam logic [12:0] FB_BYTES     = 13'd4800;
  localparam int unsigned PIPE_LATENCY = 3;

  localparam int unsigned RED_HI = 7;
  localparam int unsigned RED_LO = 5;
  localparam int unsigned GRN_HI = 4;
  localparam int unsigned GRN_LO = 2;
  localparam int unsigned BLU_HI = 1;
  localparam int unsigned BLU_LO = 0;

  typedef struct packed {
    logic active;
    logic hs_n;
    logic vs_n;
    logic fs;
  } vga_ctl_t;

  localparam vga_ctl_t CTL_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1, fs: 1'b0};

  // row*80 is built as row*64 + row*16 so no multiplier is needed.
  function automatic logic [12:0] cell_addr(input logic [9:0] h, input logic [9:0] v);
    logic [12:0] row;
    logic [12:0] col;
    row = 13'(v >> CELL_SHIFT);
    col = 13'(h >> CELL_SHIFT);
    return (row << 6) + (row << 4) + col;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel/line counters and the stage-0 decode of active video, syncs and
// frame start. The vertical geometry is a parameter so short frames can be built.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter logic [9:0] V_VIS = V_VISIBLE,
  parameter logic [9:0] V_FRT = V_FRONT,
  parameter logic [9:0] V_SYN = V_SYNC,
  parameter logic [9:0] V_BCK = V_BACK
) (
  input  logic       clk,
  input  logic       reset,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output vga_ctl_t   ctl_o
);

  localparam logic [9:0] V_TOT = V_VIS + V_FRT + V_SYN + V_BCK;
  localparam logic [9:0] VS_ST = V_VIS + V_FRT;
  localparam logic [9:0] VS_EN = VS_ST + V_SYN;

  logic [9:0] hcount_q;
  logic [9:0] hcount_d;
  logic [9:0] vcount_q;
  logic [9:0] vcount_d;

  always_comb begin
    hcount_d = hcount_q + 10'd1;
    vcount_d = vcount_q;
    if (hcount_q == H_TOTAL - 10'd1) begin
      hcount_d = 10'd0;
      if (vcount_q == V_TOT - 10'd1) begin
        vcount_d = 10'd0;
      end else begin
        vcount_d = vcount_q + 10'd1;
      end
    end else begin
      vcount_d = vcount_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign hcount_o     = hcount_q;
  assign vcount_o     = vcount_q;
  assign ctl_o.active = (hcount_q < H_VISIBLE) && (vcount_q < V_VIS);
  assign ctl_o.hs_n   = !((hcount_q >= HS_START) && (hcount_q < HS_END));
  assign ctl_o.vs_n   = !((vcount_q >= VS_ST) && (vcount_q < VS_EN));
  assign ctl_o.fs     = (hcount_q == 10'd0) && (vcount_q == 10'd0);

endmodule

// File: rtl/vga_display_ctrl.sv
// VGA display controller: issues VRAM read addresses for each 8x8 cell and
// realigns the returned colour with sync over a fixed three-clock pipeline.
module vga_display_ctrl
  import vga_timing_pkg::*;
#(
  parameter logic [9:0] V_VIS = V_VISIBLE,
  parameter logic [9:0] V_FRT = V_FRONT,
  parameter logic [9:0] V_SYN = V_SYNC,
  parameter logic [9:0] V_BCK = V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  output logic [12:0] displayAddr,
  input  logic [7:0]  displayRdData,
  output logic [2:0]  vgaRed,
  output logic [2:0]  vgaGreen,
  output logic [1:0]  vgaBlue,
  output logic        hsync,
  output logic        vsync,
  output logic        frameStart
);

  logic [9:0]  hcount;
  logic [9:0]  vcount;
  vga_ctl_t    ctl0;
  vga_ctl_t    ctl1_q;
  vga_ctl_t    ctl2_q;
  logic [12:0] addr_d;
  logic [12:0] addr_q;
  logic [2:0]  red_d;
  logic [2:0]  red_q;
  logic [2:0]  green_d;
  logic [2:0]  green_q;
  logic [1:0]  blue_d;
  logic [1:0]  blue_q;
  logic        hsync_q;
  logic        vsync_q;
  logic        fs_q;

  vga_timing_gen #(
    .V_VIS (V_VIS),
    .V_FRT (V_FRT),
    .V_SYN (V_SYN),
    .V_BCK (V_BCK)
  ) u_timing (
    .clk      (clk),
    .reset    (reset),
    .hcount_o (hcount),
    .vcount_o (vcount),
    .ctl_o    (ctl0)
  );

  always_comb begin
    addr_d = 13'd0;
    if (ctl0.active) begin
      addr_d = cell_addr(hcount, vcount);
    end else begin
      addr_d = 13'd0;
    end
  end

  // ctl2_q lines up with the VRAM data, so it alone gates the colour.
  always_comb begin
    red_d   = 3'd0;
    green_d = 3'd0;
    blue_d  = 2'd0;
    if (ctl2_q.active) begin
      red_d   = displayRdData[RED_HI:RED_LO];
      green_d = displayRdData[GRN_HI:GRN_LO];
      blue_d  = displayRdData[BLU_HI:BLU_LO];
    end else begin
      red_d   = 3'd0;
      green_d = 3'd0;
      blue_d  = 2'd0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q  <= 13'd0;
      ctl1_q  <= CTL_IDLE;
      ctl2_q  <= CTL_IDLE;
      red_q   <= 3'd0;
      green_q <= 3'd0;
      blue_q  <= 2'd0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      fs_q    <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      ctl1_q  <= ctl0;
      ctl2_q  <= ctl1_q;
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
      hsync_q <= ctl2_q.hs_n;
      vsync_q <= ctl2_q.vs_n;
      fs_q    <= ctl2_q.fs;
    end
  end

  assign displayAddr = addr_q;
  assign vgaRed      = red_q;
  assign vgaGreen    = green_q;
  assign vgaBlue     = blue_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign frameStart  = fs_q;

endmodule

// File: doc/vga_display_ctrl.md
Name: vga_display_ctrl

Overview:
- Display-side consumer of the dual-port video RAM.
- Generates 640x480@60 VGA timing from the pixel clock and drives the VRAM display-side read address.
- Takes the registered read data back from VRAM and outputs colour and sync to the DAC/connector.
- Framebuffer is 80x60 cells of one byte each (4800 bytes, addresses 0..4799); each cell is an 8x8 screen-pixel block, colour format RRRGGGBB.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- CELL_SHIFT, 3, log2 of the cell edge in pixels
- COLS, 80, cells per row (H_VISIBLE >> CELL_SHIFT)

Ports:
- clk  in  1  pixel clock, 25.175 MHz nominal
- reset  in  1  asynchronous, active-high
- displayAddr  out  13  VRAM display-side read address
- displayRdData  in  8  VRAM display-side read data; registered, valid 1 clk after the address is sampled
- vgaRed  out  3  red, displayRdData[7:5]
- vgaGreen  out  3  green, displayRdData[4:2]
- vgaBlue  out  2  blue, displayRdData[1:0]
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- frameStart  out  1  one-clock pulse aligned with the first visible pixel (0,0) on the outputs

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. No clock enable; every clk edge is one pixel.
- Reset values: hcount=0, vcount=0, displayAddr=0, all colour outputs 0, hsync=1, vsync=1, frameStart=0. All pipeline stage registers are cleared.
- Reset asserted mid-frame: outputs take their reset values immediately. On release, the frame restarts at (0,0).
- Counters:
  - hcount runs 0..799 and wraps to 0.
  - vcount increments when hcount wraps, runs 0..524 and wraps to 0 (at hcount=799, vcount=524).
- Stage 0 (counters), decoded from hcount/vcount:
  - active = h<640 && v<480
  - hs_n low for 656<=h<752
  - vs_n low for 490<=v<492
  - fs = (h==0 && v==0)
- Stage 1: displayAddr is registered.
  - Address = (v>>3)*80 + (h>>3) when active; 0 otherwise.
  - Multiply is implemented as (r<<6)+(r<<4), with r = v>>3. Arithmetic is unsigned, 13 bits.
  - Maximum address is 4799; there is no wrap or overflow.
- Stage 2: VRAM returns displayRdData for the address issued in stage 1.
- Stage 3 (output register):
  - Colour outputs = displayRdData fields if the delayed active is 1, else 0.
  - hsync, vsync and frameStart are the stage-0 values delayed by 3 clocks.
- Latency: stage-0 pixel (x,y) appears on every output exactly 3 clocks after the counters hold (x,y). Sync and colour are mutually aligned. Blanking is exact: colour is 0 on every clock where hsync or vsync is low, or in the porches.
- Counting conventions:
  - hsync period is 800 clk, low for 96.
  - vsync period is 420000 clk, low for 1600 (2 full lines), with edges coincident with hsync-domain line boundary h=0 (+3 latency).
- displayRdData is a don't-care during blanking; its value never reaches the colour outputs.
- No backpressure and no handshake. VRAM must honour its fixed 1-clk read latency on every cycle.

Decomposition:
- Shared package vga_timing_pkg holds:
  - the timing constants above
  - derived H_TOTAL=800, V_TOTAL=525
  - HS_START/HS_END, VS_START/VS_END
  - PIPE_LATENCY=3
  - FB_BYTES=4800
  - colour field bit positions
- One sub-module is natural: vga_timing_gen (hcount, vcount, active, hs_n, vs_n, fs).
- vga_display_ctrl instantiates vga_timing_gen and adds the address, delay and colour pipeline.

Test Plan:
- Release reset, run 2 frames with a VRAM model (1-clk registered read) -> hsync low exactly 96 clk every 800 clk; vsync low exactly 1600 clk every 420000 clk; frameStart pulses once per 420000 clk.
- Preload VRAM addr 0=0xE0, addr 1=0x1C, addr 80=0x03 -> output pixels x=0..7 line 0 are red=7/green=0/blue=0; x=8..15 line 0 are green=7; x=0..7 lines 8..15 are blue=3; the first colour appears 3 clk after counters reach (0,0), coincident with frameStart.
- Monitor displayAddr over a full frame -> values 0..4799 only; addr changes every 8 clk across a line; line y=479 pixel x=639 gives 4799; addr is 0 during blanking.
- Fill VRAM with 0xFF -> colour outputs are all-ones only in the visible window and 0 in all porches and sync regions (checked at h=640..799 and v=480..524).
- Assert reset at v=200, h=300 for 5 clk -> outputs go to reset values asynchronously, before the next edge; after release, hsync first falls 656+3 clk later and frameStart pulses 3 clk after release.
